// File: rtl/alu_md_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_control_unit
// Description : EX-stage ALU control decoder for RV32I. It also contains an
//               iterative RV32M multiply/divide sequencer with a valid/ready
//               handshake and a busy stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_control_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            in_valid,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic [3:0]      alu_control,
  output logic            md_sel,
  output logic            in_ready,
  output logic            md_busy,
  output logic            out_valid,
  output logic [XLEN-1:0] md_result
);

  localparam int                CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [6:0]        F7_ALT   = 7'b0100000;
  localparam logic [6:0]        F7_M     = 7'b0000001;
  localparam logic [XLEN-1:0]   XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // Upper half: partial product / partial remainder.
  // Lower half: multiplier being consumed / dividend shifting into quotient.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mag_q, mag_d;      // multiplicand or divisor magnitude
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;      // final result must be negated
  logic [XLEN-1:0]     result_q, result_d;

  assign md_sel    = ENABLE_M && (alu_op == 2'b10) && (funct7 == F7_M);
  assign in_ready  = (state_q == S_IDLE);
  assign md_busy   = !in_ready || (in_valid && md_sel);
  assign out_valid = (state_q == S_DONE) && !flush;
  assign md_result = result_q;

  // Base RV32I decode; M ops force ADD so the ALU output is ignored harmlessly
  always_comb begin
    alu_control = 4'd0;
    case (alu_op)
      2'b00: alu_control = 4'd0;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: alu_control = 4'd1;
          3'b100, 3'b101: alu_control = 4'd5;
          3'b110, 3'b111: alu_control = 4'd6;
          default:        alu_control = 4'd0;
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  alu_control = (alu_op == 2'b10 && funct7 == F7_ALT) ? 4'd1 : 4'd0;
          3'b001:  alu_control = 4'd2;
          3'b010:  alu_control = 4'd5;
          3'b011:  alu_control = 4'd6;
          3'b100:  alu_control = 4'd9;
          3'b101:  alu_control = (funct7 == F7_ALT) ? 4'd4 : 4'd3;
          3'b110:  alu_control = 4'd8;
          default: alu_control = 4'd7;
        endcase
      end
    endcase
    if (md_sel) alu_control = 4'd0;
  end

  // Operand conditioning at accept time: signedness, magnitudes, special cases
  logic            w_start, w_is_div, w_a_signed, w_b_signed;
  logic            w_sign_a, w_sign_b, w_div_zero, w_ovf, w_neg_start;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special;

  always_comb begin
    w_start     = in_valid && md_sel && (state_q == S_IDLE) && !flush;
    w_is_div    = funct3[2];
    // MUL, MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU keeps rs2 unsigned
    w_a_signed  = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    w_b_signed  = w_a_signed && (funct3 != 3'b010);
    w_sign_a    = w_a_signed && op_a[XLEN-1];
    w_sign_b    = w_b_signed && op_b[XLEN-1];
    w_a_mag     = w_sign_a ? -op_a : op_a;
    w_b_mag     = w_sign_b ? -op_b : op_b;
    w_div_zero  = w_is_div && (op_b == '0);
    w_ovf       = w_is_div && !funct3[0] && (op_a == XMIN) && (op_b == '1);
    // Remainder follows the dividend sign; everything else is sign_a ^ sign_b
    w_neg_start = (w_is_div && funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
    w_special   = '0;
    if (w_div_zero)  w_special = funct3[1] ? op_a : '1;
    else if (w_ovf)  w_special = funct3[1] ? '0 : XMIN;
  end

  // One iteration of shift-add multiply or restoring divide, plus final fix-up
  logic [XLEN:0]     w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_step, w_prod;
  logic [XLEN-1:0]   w_div_val, w_final;

  always_comb begin
    w_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    w_mul_next = {w_sum, acc_q[XLEN-1:1]};
    w_shift    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    w_diff     = w_shift - {1'b0, mag_q};
    if (!w_diff[XLEN])
      w_div_next = {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      w_div_next = {w_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    w_step     = op_q[2] ? w_div_next : w_mul_next;
    w_prod     = neg_q ? -w_step : w_step;
    w_div_val  = op_q[1] ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
    if (op_q[2])
      w_final = neg_q ? -w_div_val : w_div_val;
    else if (op_q[1:0] == 2'b00)
      w_final = w_prod[XLEN-1:0];
    else
      w_final = w_prod[2*XLEN-1:XLEN];
  end

  // Sequencer next-state logic; flush overrides every transition
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          op_d  = funct3;
          neg_d = w_neg_start;
          cnt_d = '0;
          if (w_is_div) begin
            mag_d = w_b_mag;
            acc_d = {{XLEN{1'b0}}, w_a_mag};
          end else begin
            mag_d = w_a_mag;
            acc_d = {{XLEN{1'b0}}, w_b_mag};
          end
          if (w_div_zero || w_ovf) begin
            result_d = w_special;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = w_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = w_final;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_md_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_md_control_unit
// Description : Directed, table-driven bench for alu_md_control_unit
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_md_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        in_valid;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic [3:0]  alu_control;
  logic        md_sel, in_ready, md_busy, out_valid;
  logic [31:0] md_result;

  int passed = 0;
  int total  = 0;

  alu_md_control_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .in_valid    (in_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .alu_control (alu_control),
    .md_sel      (md_sel),
    .in_ready    (in_ready),
    .md_busy     (md_busy),
    .out_valid   (out_valid),
    .md_result   (md_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] ctl;
    logic       sel;
  } dec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } md_t;

  dec_t dv[$];
  md_t  mv[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Issue one M op, hold it until out_valid, check latency, result and stall.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat);
    int cyc;
    int bad;
    @(negedge clk);
    alu_op = 2'b10; funct7 = 7'b0000001; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    #1 check("pre_accept_ready_busy", {62'd0, in_ready, md_busy}, 64'd3);
    @(posedge clk);
    cyc = 0;
    bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!out_valid && (in_ready || !md_busy)) bad++;
    end while (!out_valid && cyc < 100);
    check("md_latency", 64'(cyc), 64'(lat));
    check("md_result", {32'd0, md_result}, {32'd0, res});
    check("stall_window", 64'(bad), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int p1;
    int p2;
    int cyc;
    logic [31:0] prev;

    // alu_op, funct3, funct7, expected alu_control, expected md_sel
    dv.push_back(dec_t'{2'b10, 3'b000, 7'h20, 4'd1, 1'b0});
    dv.push_back(dec_t'{2'b11, 3'b101, 7'h00, 4'd3, 1'b0});
    dv.push_back(dec_t'{2'b01, 3'b110, 7'h00, 4'd6, 1'b0});
    dv.push_back(dec_t'{2'b00, 3'b111, 7'h20, 4'd0, 1'b0});
    dv.push_back(dec_t'{2'b01, 3'b001, 7'h00, 4'd1, 1'b0});
    dv.push_back(dec_t'{2'b01, 3'b101, 7'h00, 4'd5, 1'b0});
    dv.push_back(dec_t'{2'b01, 3'b010, 7'h00, 4'd0, 1'b0});
    dv.push_back(dec_t'{2'b11, 3'b000, 7'h20, 4'd0, 1'b0});
    dv.push_back(dec_t'{2'b11, 3'b101, 7'h20, 4'd4, 1'b0});
    dv.push_back(dec_t'{2'b10, 3'b001, 7'h00, 4'd2, 1'b0});
    dv.push_back(dec_t'{2'b10, 3'b010, 7'h00, 4'd5, 1'b0});
    dv.push_back(dec_t'{2'b10, 3'b011, 7'h00, 4'd6, 1'b0});
    dv.push_back(dec_t'{2'b10, 3'b100, 7'h00, 4'd9, 1'b0});
    dv.push_back(dec_t'{2'b10, 3'b110, 7'h00, 4'd8, 1'b0});
    dv.push_back(dec_t'{2'b10, 3'b111, 7'h00, 4'd7, 1'b0});
    dv.push_back(dec_t'{2'b10, 3'b000, 7'h01, 4'd0, 1'b1});
    dv.push_back(dec_t'{2'b10, 3'b100, 7'h01, 4'd0, 1'b1});
    dv.push_back(dec_t'{2'b11, 3'b100, 7'h01, 4'd9, 1'b0});

    // funct3, op_a, op_b, expected md_result, cycles from accept to out_valid
    mv.push_back(md_t'{3'b000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 33});
    mv.push_back(md_t'{3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    mv.push_back(md_t'{3'b011, 32'hFFFFFFFF, 32'd2,        32'h00000001, 33});
    mv.push_back(md_t'{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    mv.push_back(md_t'{3'b000, 32'd12345,    32'd6789,     32'h04FED79D, 33});
    mv.push_back(md_t'{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    mv.push_back(md_t'{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    mv.push_back(md_t'{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    mv.push_back(md_t'{3'b101, 32'd7,        32'd2,        32'd3,        33});
    mv.push_back(md_t'{3'b111, 32'd7,        32'd2,        32'd1,        33});
    mv.push_back(md_t'{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33});
    mv.push_back(md_t'{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        33});
    mv.push_back(md_t'{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33});
    mv.push_back(md_t'{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
    mv.push_back(md_t'{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    mv.push_back(md_t'{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    mv.push_back(md_t'{3'b110, 32'd5,        32'd0,        32'd5,        1});
    mv.push_back(md_t'{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    mv.push_back(md_t'{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});

    rst = 1'b1; alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00;
    in_valid = 1'b0; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready",     {63'd0, in_ready},  64'd1);
    check("reset_busy",      {63'd0, md_busy},   64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result",    {32'd0, md_result}, 64'd0);

    foreach (dv[i]) begin
      @(negedge clk);
      alu_op = dv[i].op; funct3 = dv[i].f3; funct7 = dv[i].f7;
      #1;
      check($sformatf("decode_ctl[%0d]", i), {60'd0, alu_control}, {60'd0, dv[i].ctl});
      check($sformatf("decode_sel[%0d]", i), {63'd0, md_sel},      {63'd0, dv[i].sel});
    end

    foreach (mv[i]) run_md(mv[i].f3, mv[i].a, mv[i].b, mv[i].res, mv[i].lat);

    // A valid base R-type op must not start the sequencer
    @(negedge clk);
    alu_op = 2'b10; funct7 = 7'h00; funct3 = 3'b000; in_valid = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!in_ready || md_busy || out_valid) bad++;
    end
    check("base_op_no_start", 64'(bad), 64'd0);
    in_valid = 1'b0;

    // Flush during cycle 10 of a DIV
    prev = md_result;
    @(negedge clk);
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b100; op_a = 32'hFFFFFFF9; op_b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid || in_ready) bad++;
    end
    flush = 1'b1; in_valid = 1'b0;
    #1 check("flush_no_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle_next", {63'd0, in_ready}, 64'd1);
    check("flush_result_held", {32'd0, md_result}, {32'd0, prev});
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("flush_quiet", 64'(bad), 64'd0);
    run_md(3'b000, 32'd3, 32'd7, 32'd21, 33);

    // Back-to-back MULs with in_valid held high
    @(negedge clk);
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    p1 = -1; p2 = -1; cyc = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      cyc = i;
      if (i == 34) check("b2b_idle_busy", {62'd0, in_ready, md_busy}, 64'd3);
      if (out_valid) begin
        if (p1 < 0) p1 = cyc;
        else p2 = cyc;
      end
      if (p2 >= 0) break;
    end
    in_valid = 1'b0;
    check("b2b_first_pulse", 64'(p1), 64'd33);
    check("b2b_spacing", 64'(p2 - p1), 64'd34);
    check("b2b_result", {32'd0, md_result}, 64'd15);

    // Reset during cycle 5 of a MULHU
    @(negedge clk);
    @(negedge clk);
    alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b011; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_result",    {32'd0, md_result}, 64'd0);
    check("rst_mid_ready",     {63'd0, in_ready},  64'd1);
    rst = 1'b0; in_valid = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("rst_mid_quiet", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_md_control_unit.md
Name: alu_md_control_unit

Overview:
- Next-generation ALU control block. Decodes alu_op/funct3/funct7 into the 4-bit ALU control code for RV32I (combinational).
- Adds RV32M (funct7=0000001) support through an internal iterative multiply/divide sequencer with a valid/ready handshake and a busy signal for pipeline stall.
- Sits in EX beside the ALU. Writeback muxes md_result when md_sel is high.

Parameters:
XLEN, 32, operand/result width (even, >=8)
ENABLE_M, 1, 1 = decode and execute RV32M; 0 = funct7=0000001 decodes as the base op, sequencer never starts

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_op  in  2  00 load/store/add, 01 branch, 10 R-type, 11 I-type
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
in_valid  in  1  EX holds a valid instruction/operands
op_a  in  XLEN  rs1 value
op_b  in  XLEN  rs2 value
flush  in  1  abort in-flight M op
alu_control  out  4  0 ADD,1 SUB,2 SLL,3 SRL,4 SRA,5 SLT,6 SLTU,7 AND,8 OR,9 XOR
md_sel  out  1  decoded op is an M op (combinational)
in_ready  out  1  sequencer idle
md_busy  out  1  sequencer not idle; stall request
out_valid  out  1  one-cycle pulse, md_result valid
md_result  out  XLEN  M-op result

Behaviour:
- Base decode (combinational):
  - alu_op 00 -> 0.
  - 01: funct3 000/001 -> 1; 100/101 -> 5; 110/111 -> 6; else 0.
  - 10 and 11: 000 -> ADD (SUB if alu_op=10 and funct7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (SRA if funct7=0100000); 110 OR; 111 AND.
- md_sel = ENABLE_M & alu_op==10 & funct7==0000001. When md_sel=1, alu_control=0.
- M funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start when in_valid & md_sel & in_ready. Latch op, operand magnitudes, result sign; cnt=0.
  - Start with op=DIV/DIVU/REM/REMU and op_b=0 -> DONE directly.
  - Start with op=DIV/REM, op_a=-2^(XLEN-1), op_b=-1 -> DONE directly.
  - Otherwise IDLE -> CALC.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle for XLEN cycles. cnt increments; at cnt==XLEN-1 -> DONE.
  - DONE: out_valid=1 for exactly one cycle, then -> IDLE.
- Latency from the accept edge:
  - Normal: out_valid in cycle XLEN+1 (33 for XLEN=32).
  - Special cases: out_valid in cycle 1.
- in_ready = (state==IDLE). md_busy = !in_ready | (in_valid & md_sel & state==IDLE). EX holds operands until out_valid.
- Back-to-back: the IDLE cycle after DONE may accept a new op. md_busy is high in that IDLE cycle if an M op is pending.
- Signed/unsigned handling:
  - Operands are converted to magnitudes per op signedness; MULHSU treats op_a signed, op_b unsigned.
  - The 2*XLEN-bit product is negated if its sign is set.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient sign = sign_a ^ sign_b. Remainder takes sign_a.
- Special results:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Overflow: DIV -> -2^(XLEN-1); REM -> 0.
- md_result holds its value until the next DONE.
- flush: any state -> IDLE next cycle; no out_valid; md_result unchanged. flush wins over a simultaneous start.
- Reset: state=IDLE, cnt=0, out_valid=0, md_result=0, internal registers=0. in_ready=1, md_busy=0 (given in_valid=0). Reset mid-CALC aborts with no out_valid.
- ENABLE_M=0: md_sel=0; FSM stays in IDLE.
- in_valid & !md_sel never starts the sequencer.

Test Plan:
- Base decode sweep: alu_op=10, funct3=000, funct7=0100000 -> alu_control=1, md_sel=0. alu_op=11, funct3=101, funct7=0 -> 3. alu_op=01, funct3=110 -> 6.
- MUL/MULH: op_a=0xFFFFFFFF, op_b=2. MUL -> 0xFFFFFFFE with out_valid at cycle 33. MULH -> 0xFFFFFFFF. MULHU -> 0x00000001. in_ready=0 during cycles 1-32.
- DIV/REM signed: op_a=-7, op_b=2. DIV -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). DIVU 7/2 -> 3.
- Special cases: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0. Each has out_valid at cycle 1.
- Flush: assert flush at cycle 10 of a DIV -> state IDLE at cycle 11, no out_valid, md_result unchanged. A new MUL accepted afterwards completes normally.
- Reset mid-op: rst at cycle 5 of MULHU -> out_valid=0, md_result=0, in_ready=1 next cycle. Back-to-back MUL ops -> out_valid pulses spaced 34 cycles apart.
